// File: rtl/mem_pkg.sv
// Shared types for the CPU-side memory responder: access sizes, FSM states, default geometry.
package mem_pkg;

  localparam int ADDR_BITS_DEF = 8;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with four independent byte write lanes and a registered 4-byte big-endian read.
// Read data appears one edge after rd_addr is sampled; same-edge writes are not visible until the following read.
module mem_byte_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                       clk,
  input  logic [3:0]                 we,
  input  logic [3:0][ADDR_BITS-1:0]  idx,
  input  logic [3:0][7:0]            wdat,
  input  logic [ADDR_BITS-1:0]       rd_addr,
  input  logic                       rd_clr,
  output logic [31:0]                rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]  mem_q [DEPTH];
  logic [31:0] rdata_d, rdata_q;
  logic [3:0][ADDR_BITS-1:0] rd_idx;

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < 4; i++) begin
      rd_idx[i] = rd_addr + ADDR_BITS'(i);
    end
    if (!rd_clr) begin
      rdata_d = {mem_q[rd_idx[0]], mem_q[rd_idx[1]], mem_q[rd_idx[2]], mem_q[rd_idx[3]]};
    end
  end

  // The array is deliberately never reset so a reboot only overwrites what the new image covers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[idx[i]] <= wdat[i];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU memory port: preloads the image from a byte stream while holding the CPU, then serves 1-cycle reads and sized writes.
// boot_ready/cpu_hold depend only on the registered state; reads are registered, writes land at the sampling edge.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_DEF,
  parameter int BOOT_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  input  logic        boot_valid,
  input  logic [7:0]  boot_byte,
  input  logic        boot_done,
  output logic        boot_ready,
  output logic        cpu_hold
);

  localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(BOOT_BYTES - 1);

  state_e                    state_d, state_q;
  logic [ADDR_BITS-1:0]      ptr_d, ptr_q;
  logic [ADDR_BITS-1:0]      addr;
  logic [3:0]                arr_we;
  logic [3:0][ADDR_BITS-1:0] arr_idx;
  logic [3:0][7:0]           arr_wdat;
  logic                      rd_clr;
  logic                      unused_addr_hi;

  assign addr           = Address[ADDR_BITS-1:0];
  assign unused_addr_hi = ^Address[31:ADDR_BITS];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    arr_we   = '0;
    arr_wdat = '0;
    for (int i = 0; i < 4; i++) begin
      arr_idx[i] = addr + ADDR_BITS'(i);
    end
    case (state_q)
      ST_BOOT: begin
        // Boot bytes always go through lane 0 at the boot pointer.
        if (boot_valid) begin
          arr_we[0]   = 1'b1;
          arr_idx[0]  = ptr_q;
          arr_wdat[0] = boot_byte;
          ptr_d       = ptr_q + ADDR_BITS'(1);
        end
        if (boot_done || (boot_valid && ptr_q == LAST_PTR)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (wr) begin
          case (size)
            SZ_HALF: begin
              arr_we      = 4'b0011;
              arr_wdat[0] = datain[15:8];
              arr_wdat[1] = datain[7:0];
            end
            SZ_BYTE: begin
              arr_we      = 4'b0001;
              arr_wdat[0] = datain[7:0];
            end
            default: begin
              arr_we = 4'b1111;
              for (int i = 0; i < 4; i++) begin
                arr_wdat[i] = datain[31-8*i -: 8];
              end
            end
          endcase
        end
      end
    endcase
    if (reset) begin
      arr_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rd_clr     = reset || (state_q == ST_BOOT);
  assign boot_ready = (state_q == ST_BOOT);
  assign cpu_hold   = (state_q == ST_BOOT);

  mem_byte_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .idx     (arr_idx),
    .wdat    (arr_wdat),
    .rd_addr (addr),
    .rd_clr  (rd_clr),
    .rdata   (dataout)
  );

endmodule
